// File: rtl/adder_four_pkg.sv
// Shared datapath constants for the adder_four slice.
// Holds the width/increment defaults and the lookahead grouping used by adder_core.
package adder_four_pkg;

   // Datapath width limits and defaults.
   localparam int          DATA_WIDTH_MIN  = 3;
   localparam int          DATA_WIDTH_MAX  = 64;
   localparam int          ADDER_WIDTH_DEF = 32;
   localparam logic [63:0] INCREMENT_DEF   = 64'd4;

   // Carry-lookahead group size; groups ripple their carry into the next group.
   localparam int CLA_GROUP_W = 4;

   function automatic int cla_groups(input int width);
      return (width + CLA_GROUP_W - 1) / CLA_GROUP_W;
   endfunction

endpackage

// File: rtl/adder_core.sv
// Generic two-operand unsigned adder with carry-in/carry-out.
// Carries are resolved by lookahead inside each 4-bit group; group carries ripple between groups.
module adder_core
   import adder_four_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEF
)
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int NUM_GROUPS = cla_groups(WIDTH);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_GROUPS; gi++) begin : gen_grp
         localparam int BASE = gi * CLA_GROUP_W;
         localparam int TOP  = ((BASE + CLA_GROUP_W - 1) < WIDTH) ? (BASE + CLA_GROUP_W - 1) : (WIDTH - 1);
         localparam int GW   = TOP - BASE + 1;

         logic          cin;
         logic          cout;
         logic [GW-1:0] gen_bits;
         logic [GW-1:0] prop_bits;
         logic [GW:0]   carry_bits;

         if (gi == 0) begin : gen_cin_first
            assign cin = carry_in;
         end else begin : gen_cin_chain
            assign cin = gen_grp[gi-1].cout;
         end

         assign gen_bits  = a[TOP:BASE] & b[TOP:BASE];
         assign prop_bits = a[TOP:BASE] ^ b[TOP:BASE];

         // Every carry in the group is a flat sum of products of g/p terms and the
         // group carry-in, so no bit waits on its neighbour's carry net.
         always_comb begin
            logic c_acc;
            c_acc      = 1'b0;
            carry_bits = '0;
            for (int j = 0; j <= GW; j++) begin
               c_acc = cin;
               for (int k = 0; k < j; k++) begin
                  c_acc = gen_bits[k] | (prop_bits[k] & c_acc);
               end
               carry_bits[j] = c_acc;
            end
         end

         assign sum[TOP:BASE] = prop_bits ^ carry_bits[GW-1:0];
         assign cout          = carry_bits[GW];
      end
   endgenerate

   assign carry_out = gen_grp[NUM_GROUPS-1].cout;

endmodule

// File: rtl/adder_four.sv
// Adds a constant INCREMENT to a_input: live combinational result plus a
// one-cycle registered copy qualified by in_valid.
module adder_four
   import adder_four_pkg::*;
#(
   parameter int          ADDER_WIDTH = ADDER_WIDTH_DEF,
   parameter logic [63:0] INCREMENT   = INCREMENT_DEF
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDER_WIDTH-1:0] a_input,
   input  logic                   in_valid,
   output logic [ADDER_WIDTH-1:0] sum,
   output logic                   carry_out,
   output logic [ADDER_WIDTH-1:0] sum_q,
   output logic                   carry_q,
   output logic                   out_valid
);

   localparam logic [ADDER_WIDTH-1:0] INC_OPERAND = ADDER_WIDTH'(INCREMENT);

   logic [ADDER_WIDTH-1:0] sum_q_reg,     sum_q_next;
   logic                   carry_q_reg,   carry_q_next;
   logic                   out_valid_reg, out_valid_next;
   logic                   load_en;

   adder_core #(
      .WIDTH     (ADDER_WIDTH)
   ) u_adder_core (
      .a         (a_input),
      .b         (INC_OPERAND),
      .carry_in  (1'b0),
      .sum       (sum),
      .carry_out (carry_out)
   );

   // Only a clean 1 loads; an unknown valid must never corrupt the held result.
   assign load_en = (in_valid === 1'b1);

   always_comb begin
      sum_q_next     = sum_q_reg;
      carry_q_next   = carry_q_reg;
      out_valid_next = 1'b0;
      if (!rst_n) begin
         sum_q_next   = '0;
         carry_q_next = 1'b0;
      end else if (load_en) begin
         sum_q_next     = sum;
         carry_q_next   = carry_out;
         out_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      sum_q_reg     <= sum_q_next;
      carry_q_reg   <= carry_q_next;
      out_valid_reg <= out_valid_next;
   end

   assign sum_q     = sum_q_reg;
   assign carry_q   = carry_q_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_adder_four.sv
// Directed checks of adder_four (32-bit, INCREMENT=4) plus a random sweep on 32- and 8-bit instances.
module tb_adder_four;

   logic        clk;
   logic        rst_n;
   logic [31:0] a_input;
   logic        in_valid;
   logic [31:0] sum, sum_q;
   logic        carry_out, carry_q, out_valid;

   logic [7:0]  a8;
   logic        in_valid8;
   logic [7:0]  sum8, sum_q8;
   logic        carry8, carry_q8, out_valid8;

   logic        clk_run;
   int          n_cmp;
   int          n_err;

   adder_four u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_input   (a_input),
      .in_valid  (in_valid),
      .sum       (sum),
      .carry_out (carry_out),
      .sum_q     (sum_q),
      .carry_q   (carry_q),
      .out_valid (out_valid)
   );

   adder_four #(.ADDER_WIDTH(8), .INCREMENT(64'd4)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_input   (a8),
      .in_valid  (in_valid8),
      .sum       (sum8),
      .carry_out (carry8),
      .sum_q     (sum_q8),
      .carry_q   (carry_q8),
      .out_valid (out_valid8)
   );

   // Clock stays undriven until the first combinational checks are done.
   initial begin
      wait (clk_run);
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic comb(input logic [31:0] a, input logic [31:0] exp_s, input logic exp_c);
      a_input = a;
      #1;
      $display("comb a=%0h sum=%0h carry=%0b", a, sum, carry_out);
      check("comb_sum", 64'(sum), 64'(exp_s));
      check("comb_carry", 64'(carry_out), 64'(exp_c));
   endtask

   task automatic edge_chk(input string tag, input logic [31:0] exp_sq, input logic exp_cq, input logic exp_ov);
      @(posedge clk);
      #1;
      $display("%s: sum_q=%0h carry_q=%0b out_valid=%0b", tag, sum_q, carry_q, out_valid);
      check({tag, "_sum_q"}, 64'(sum_q), 64'(exp_sq));
      check({tag, "_carry_q"}, 64'(carry_q), 64'(exp_cq));
      check({tag, "_out_valid"}, 64'(out_valid), 64'(exp_ov));
   endtask

   initial begin
      logic [32:0] ref32;
      logic [8:0]  ref8;
      n_cmp     = 0;
      n_err     = 0;
      clk_run   = 1'b0;
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
      a8        = 8'd0;
      a_input   = 32'd0;

      // Combinational path with clk and rst_n never driven.
      #10;
      $display("float a=0 sum=%0h carry=%0b", sum, carry_out);
      check("float_sum", 64'(sum), 64'd4);
      check("float_carry", 64'(carry_out), 64'd0);

      comb(32'd10,         32'd14,         1'b0);
      comb(32'd100,        32'd104,        1'b0);
      comb(32'd4294967290, 32'd4294967294, 1'b0);
      comb(32'hFFFF_FFFB,  32'hFFFF_FFFF,  1'b0);
      comb(32'hFFFF_FFFC,  32'h0000_0000,  1'b1);
      comb(32'hFFFF_FFFF,  32'h0000_0003,  1'b1);
      comb(32'h0000_FFFF,  32'h0001_0003,  1'b0);

      // Registered path.
      rst_n   = 1'b0;
      clk_run = 1'b1;
      #2;
      @(posedge clk);
      edge_chk("reset", 32'd0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b1; a_input = 32'd10;
      edge_chk("load10", 32'd14, 1'b0, 1'b1);

      @(negedge clk);
      in_valid = 1'b0; a_input = 32'd50;
      edge_chk("hold", 32'd14, 1'b0, 1'b0);

      @(negedge clk);
      in_valid = 1'b1; a_input = 32'hFFFF_FFFE;
      edge_chk("b2b_wrap", 32'd2, 1'b1, 1'b1);
      @(negedge clk);
      a_input = 32'd7;
      edge_chk("b2b_next", 32'd11, 1'b0, 1'b1);

      // Reset wins over a simultaneous load; combinational path stays live.
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1; a_input = 32'd100;
      edge_chk("rst_vs_load", 32'd0, 1'b0, 1'b0);
      check("rst_comb_sum", 64'(sum), 64'd104);
      check("rst_comb_carry", 64'(carry_out), 64'd0);

      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; a_input = 32'd33;
      edge_chk("post_rst_idle", 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; a_input = 32'd1;
      edge_chk("post_rst_load", 32'd5, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;

      // Random sweep against the bench's own reference sum.
      for (int i = 0; i < 1000; i++) begin
         a_input = $urandom;
         a8      = 8'($urandom_range(0, 255));
         #1;
         ref32 = {1'b0, a_input} + 33'd4;
         ref8  = {1'b0, a8} + 9'd4;
         assert ({carry_out, sum} === ref32) else begin
            n_err++;
            $error("FAIL sweep32: a=%0h observed %0h expected %0h", a_input, {carry_out, sum}, ref32);
         end
         n_cmp++;
         assert ({carry8, sum8} === ref8) else begin
            n_err++;
            $error("FAIL sweep8: a=%0h observed %0h expected %0h", a8, {carry8, sum8}, ref8);
         end
         n_cmp++;
      end
      $display("sweep done: 1000 samples on each width");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
